// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU: opcodes, sequencer phases and opcode classification.
// Used by the sequencer, instruction register and ALU blocks.
package cpu_pkg;

  localparam int OPC_W   = 3;
  localparam int PHASE_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  // The encoding of the eight running phases equals the debug phase index.
  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } phase_e;

  function automatic logic is_aluop(input opcode_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Eight-phase instruction controller: FSM plus INST_FETCH wait counter.
// Optional single-step control in INST_ADDR is enabled by defining SEQ_SINGLE_STEP_EN.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int OP_W        = 3,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step_mode,
  input  logic            step,
`endif
  output logic            addr_sel,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            data_en,
  output logic            ld_ir,
  output logic            ld_acc,
  output logic            alu_to_acc,
  output logic            pc_ld,
  output logic            skip_signal,
  output logic            jump,
  output logic            halt,
  output logic [2:0]      phase
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  phase_e     state_q, state_d;
  opcode_e    op_q;
  logic [2:0] wait_q;
  logic       aluop;

  assign aluop = is_aluop(op_q);

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INST_ADDR;
      op_q    <= OP_HLT;
      wait_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) op_q <= opcode_e'(opcode[OPC_W-1:0]);
      // Held at zero outside INST_FETCH, so each fetch starts a fresh count.
      if (state_q != INST_FETCH) wait_q <= 3'd0;
      else if (wait_q != WS)     wait_q <= wait_q + 3'd1;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef SEQ_SINGLE_STEP_EN
      INST_ADDR:  if (!step_mode || step) state_d = INST_FETCH;
`else
      INST_ADDR:  state_d = INST_FETCH;
`endif
      INST_FETCH: if (wait_q == WS) state_d = INST_LOAD;
      INST_LOAD:  state_d = IDLE;
      IDLE:       state_d = OP_ADDR;
      OP_ADDR:    state_d = (op_q == OP_HLT) ? HALTED : OP_FETCH;
      OP_FETCH:   state_d = ALU_OP;
      ALU_OP:     state_d = STORE;
      STORE:      state_d = INST_ADDR;
      HALTED:     state_d = HALTED;
      default:    state_d = INST_ADDR;
    endcase
  end

  always_comb begin
    addr_sel    = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    data_en     = 1'b0;
    ld_ir       = 1'b0;
    ld_acc      = 1'b0;
    alu_to_acc  = 1'b0;
    pc_ld       = 1'b0;
    skip_signal = 1'b0;
    jump        = 1'b0;
    halt        = 1'b0;
    phase       = state_q[2:0];
    case (state_q)
      INST_ADDR: addr_sel = 1'b1;
      INST_FETCH: begin
        addr_sel = 1'b1;
        mem_rd   = 1'b1;
      end
      INST_LOAD, IDLE: begin
        addr_sel = 1'b1;
        mem_rd   = 1'b1;
        ld_ir    = 1'b1;
      end
      OP_ADDR: begin
        // zero is only looked at here; SKZ and JMP are exclusive so skip/jump never overlap.
        pc_ld       = (op_q != OP_HLT);
        skip_signal = (op_q == OP_SKZ) && zero;
        jump        = (op_q == OP_JMP);
      end
      OP_FETCH: mem_rd = aluop;
      ALU_OP: begin
        mem_rd     = aluop;
        ld_acc     = aluop;
        alu_to_acc = (op_q != OP_LDA);
        data_en    = (op_q == OP_STO);
      end
      STORE: begin
        data_en = (op_q == OP_STO);
        mem_wr  = (op_q == OP_STO);
      end
      HALTED: begin
        halt  = 1'b1;
        phase = 3'd4;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-phase expected outputs queued at drive time,
// popped and compared against the DUT away from the rising edge.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  opcode = 3'd2;
  logic        zero = 1'b0;
  wire  [13:0] o0;
  wire  [13:0] o3;

  int total = 0;
  int bad   = 0;
  logic [13:0] sbq[$];

  always #5 clk = ~clk;

  // Output vector: {addr_sel, mem_rd, mem_wr, data_en, ld_ir, ld_acc, alu_to_acc,
  //                 pc_ld, skip_signal, jump, halt, phase[2:0]}
  cpu_sequencer #(.OP_W(3), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(1'b0), .step(1'b0),
`endif
    .addr_sel(o0[13]), .mem_rd(o0[12]), .mem_wr(o0[11]), .data_en(o0[10]),
    .ld_ir(o0[9]), .ld_acc(o0[8]), .alu_to_acc(o0[7]), .pc_ld(o0[6]),
    .skip_signal(o0[5]), .jump(o0[4]), .halt(o0[3]), .phase(o0[2:0])
  );

  cpu_sequencer #(.OP_W(3), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(1'b0), .step(1'b0),
`endif
    .addr_sel(o3[13]), .mem_rd(o3[12]), .mem_wr(o3[11]), .data_en(o3[10]),
    .ld_ir(o3[9]), .ld_acc(o3[8]), .alu_to_acc(o3[7]), .pc_ld(o3[6]),
    .skip_signal(o3[5]), .jump(o3[4]), .halt(o3[3]), .phase(o3[2:0])
  );

  // Reference decode; p = 8 stands for the halted state.
  function automatic logic [13:0] model(input int p, input logic [2:0] op, input logic z);
    logic a = 0, rd = 0, wr = 0, de = 0, ir = 0, acc = 0, ata = 0;
    logic pc = 0, sk = 0, jp = 0, h = 0;
    logic [2:0] ph;
    logic alu;
    alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    ph  = 3'(p);
    case (p)
      0: a = 1;
      1: begin a = 1; rd = 1; end
      2, 3: begin a = 1; rd = 1; ir = 1; end
      4: begin pc = (op != 3'd0); sk = (op == 3'd1) && z; jp = (op == 3'd7); end
      5: rd = alu;
      6: begin rd = alu; acc = alu; ata = (op != 3'd5); de = (op == 3'd6); end
      7: begin de = (op == 3'd6); wr = (op == 3'd6); end
      default: begin h = 1; ph = 3'd4; end
    endcase
    return {a, rd, wr, de, ir, acc, ata, pc, sk, jp, h, ph};
  endfunction

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered at a falling edge with the DUT in INST_ADDR. Opcode is driven with the real
  // value only in IDLE and with random values elsewhere. Runs at most max_steps phases;
  // adv_last=0 leaves the bench sitting inside the final phase.
  task automatic run_instr(input bit use3, input logic [2:0] op, input logic z,
                           input int ws, input int max_steps, input bit adv_last);
    int seq[$];
    int n;
    seq.push_back(0);
    for (int k = 0; k <= ws; k++) seq.push_back(1);
    seq.push_back(2);
    seq.push_back(3);
    seq.push_back(4);
    if (op == 3'd0) begin
      for (int k = 0; k < 20; k++) seq.push_back(8);
    end else begin
      seq.push_back(5);
      seq.push_back(6);
      seq.push_back(7);
    end
    n = (max_steps < seq.size()) ? max_steps : seq.size();
    for (int i = 0; i < n; i++) begin
      opcode = (seq[i] == 3) ? op : 3'($urandom_range(7, 0));
      zero   = z;
      sbq.push_back(model(seq[i], op, z));
      #1;
      check($sformatf("ws%0d_op%0d_z%0d_step%0d_ph%0d", ws, op, z, i, seq[i]),
            use3 ? o3 : o0, sbq.pop_front());
      if (i < n - 1 || adv_last) @(negedge clk);
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must show INST_ADDR at once.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    sbq.push_back(model(0, 3'd0, 1'b0));
    sbq.push_back(model(0, 3'd0, 1'b0));
    check({tag, "_dut0"}, o0, sbq.pop_front());
    check({tag, "_dut3"}, o3, sbq.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    do_reset("reset_start");

    // ADD back to back: ld_ir cycles 2-3, pc_ld cycle 4, ld_acc cycle 6, period 8.
    run_instr(0, 3'd2, 1'b0, 0, 99, 1);
    run_instr(0, 3'd2, 1'b1, 0, 99, 1);
    // SKZ with zero set and clear, then JMP, LDA and the other ALU ops.
    run_instr(0, 3'd1, 1'b1, 0, 99, 1);
    run_instr(0, 3'd1, 1'b0, 0, 99, 1);
    run_instr(0, 3'd7, 1'b1, 0, 99, 1);
    run_instr(0, 3'd5, 1'b0, 0, 99, 1);
    run_instr(0, 3'd3, 1'b0, 0, 99, 1);
    run_instr(0, 3'd4, 1'b1, 0, 99, 1);
    run_instr(0, 3'd6, 1'b0, 0, 99, 1);

    // STO interrupted by reset while mem_wr is high in STORE.
    run_instr(0, 3'd6, 1'b0, 0, 8, 0);
    do_reset("reset_in_store");

    // Slow memory: INST_FETCH spans four cycles.
    run_instr(1, 3'd2, 1'b0, 3, 99, 1);
    run_instr(1, 3'd6, 1'b0, 3, 99, 1);

    // HLT: no pc_ld, frozen in HALTED while opcode wanders, left only by reset.
    do_reset("reset_before_hlt");
    run_instr(0, 3'd0, 1'b1, 0, 99, 1);
    do_reset("reset_from_halt");
    run_instr(0, 3'd2, 1'b0, 0, 99, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
